// File: rtl/lsu_mem_adapter.sv
// ============================================================================
// Module   : lsu_mem_adapter
// Brief    : Load/store unit bridging execute-stage requests to a byte-addressed
//            data memory, with legality/alignment/range checks and load extension.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_adapter #(
    parameter int ADDR_WIDTH  = 16,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        mem_en,
    output logic [1:0]  mem_access_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] c_ERR_OK    = 2'b00;
    localparam logic [1:0] c_ERR_ALIGN = 2'b01;
    localparam logic [1:0] c_ERR_RANGE = 2'b10;
    localparam logic [1:0] c_ERR_ILL   = 2'b11;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [1:0]  r_err;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic [1:0]  w_err;
    logic [31:0] w_load_ext;
    logic [1:0]  w_store_mode;

    generate
        if (CHECK_RANGE && (ADDR_WIDTH < 32)) begin : g_range
            assign w_out_of_range = |req_addr[31:ADDR_WIDTH];
        end else begin : g_no_range
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    // Request checks are evaluated on the live request so the error is ready
    // to latch on the accepting edge.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_err        = c_ERR_OK;
        if (req_we) begin
            w_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110);
        end
        w_misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                       ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
        if (w_illegal) begin
            w_err = c_ERR_ILL;
        end else if (w_misaligned) begin
            w_err = c_ERR_ALIGN;
        end else if (w_out_of_range) begin
            w_err = c_ERR_RANGE;
        end
    end

    always_comb begin
        w_load_ext = mem_data_out;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{mem_data_out[7]}}, mem_data_out[7:0]};
            3'b001:  w_load_ext = {{16{mem_data_out[15]}}, mem_data_out[15:0]};
            3'b100:  w_load_ext = {24'd0, mem_data_out[7:0]};
            3'b101:  w_load_ext = {16'd0, mem_data_out[15:0]};
            default: w_load_ext = mem_data_out;
        endcase
    end

    always_comb begin
        w_store_mode = 2'b11;
        case (r_funct3[1:0])
            2'b00:   w_store_mode = 2'b01;
            2'b01:   w_store_mode = 2'b10;
            default: w_store_mode = 2'b11;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_next = (w_err == c_ERR_OK) ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: w_state_next = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= c_ERR_OK;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_err    <= w_err;
                        r_rdata  <= 32'd0;
                    end
                end
                S_ACCESS: r_rdata <= r_we ? 32'd0 : w_load_ext;
                default: ;
            endcase
        end
    end

    // Memory strobes decode from state only, so the level-sensitive memory
    // can never see a write outside the single ACCESS cycle.
    assign req_ready       = (r_state == S_IDLE);
    assign rsp_valid       = (r_state == S_RESP);
    assign rsp_rdata       = r_rdata;
    assign rsp_err         = r_err;
    assign mem_en          = (r_state == S_ACCESS);
    assign mem_access_mode = ((r_state == S_ACCESS) && r_we) ? w_store_mode : 2'b00;
    assign mem_addr        = r_addr;
    assign mem_data_in     = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_adapter.sv
// ============================================================================
// Module   : tb_lsu_mem_adapter
// Brief    : Directed self-checking bench for lsu_mem_adapter with a byte memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_adapter;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_en;
    logic [1:0]  mem_access_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    int n_cmp = 0;
    int n_err = 0;
    int en_count = 0;
    int cyc = 0;
    logic [1:0]  last_mode;
    logic [7:0]  mem [0:255];
    logic [7:0]  ma;
    logic [31:0] rq[$];

    lsu_mem_adapter #(.ADDR_WIDTH(16), .CHECK_RANGE(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_en         (mem_en),
        .mem_access_mode(mem_access_mode),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign ma = mem_addr[7:0];
    assign mem_data_out = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

    // ACCESS spans exactly one negedge, so writes and enable counts land once.
    always @(negedge clk) begin
        if (mem_en) begin
            en_count  <= en_count + 1;
            last_mode <= mem_access_mode;
            case (mem_access_mode)
                2'b01: mem[ma] <= mem_data_in[7:0];
                2'b10: begin
                    mem[ma]         <= mem_data_in[7:0];
                    mem[ma + 8'd1]  <= mem_data_in[15:8];
                end
                2'b11: begin
                    mem[ma]         <= mem_data_in[7:0];
                    mem[ma + 8'd1]  <= mem_data_in[15:8];
                    mem[ma + 8'd2]  <= mem_data_in[23:16];
                    mem[ma + 8'd3]  <= mem_data_in[31:24];
                end
                default: ;
            endcase
        end
        if (rsp_valid && rsp_ready) rq.push_back(rsp_rdata);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, " rsp_err"}, {30'd0, rsp_err}, 32'd0);
        check({tag, " mem_en"}, {31'd0, mem_en}, 32'd0);
        check({tag, " mem_mode"}, {30'd0, mem_access_mode}, 32'd0);
        check({tag, " mem_addr"}, mem_addr, 32'd0);
        check({tag, " mem_data_in"}, mem_data_in, 32'd0);
    endtask

    task automatic transact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic [1:0] err, output int lat, output int ens);
        int e0;
        @(negedge clk);
        e0 = en_count;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk); #1;
        ens = en_count - e0;
    endtask

    task automatic run_check(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        logic [31:0] rd;
        logic [1:0]  er;
        int lat, ens;
        transact(we, f3, addr, wdata, rd, er, lat, ens);
        check({tag, " rdata"}, rd, exp_rdata);
        check({tag, " err"}, {30'd0, er}, {30'd0, exp_err});
        check({tag, " latency"}, lat, (exp_err == 2'b00) ? 32'd2 : 32'd1);
        check({tag, " mem_en cycles"}, ens, (exp_err == 2'b00) ? 32'd1 : 32'd0);
    endtask

    initial begin : main
        logic [2:0]  f3s   [4];
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        int          acc   [4];
        int          e0;
        logic        rdy;
        int          k;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk); rst = 1'b0;

        run_check("SW 0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00);
        check("SW mode", {30'd0, last_mode}, 32'd3);
        run_check("LW 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00);
        run_check("SB 0x20", 1'b1, 3'b000, 32'h20, 32'h00000080, 32'h0, 2'b00);
        check("SB mode", {30'd0, last_mode}, 32'd1);
        run_check("LB 0x20", 1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFF80, 2'b00);
        run_check("LBU 0x20", 1'b0, 3'b100, 32'h20, 32'h0, 32'h00000080, 2'b00);
        run_check("SH 0x22", 1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0, 2'b00);
        check("SH mode", {30'd0, last_mode}, 32'd2);
        run_check("LH 0x22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 2'b00);
        run_check("LHU 0x22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 2'b00);

        run_check("LW misaligned", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 2'b01);
        run_check("LH range", 1'b0, 3'b001, 32'h00010000, 32'h0, 32'h0, 2'b10);
        run_check("load f3 011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 2'b11);
        run_check("store f3 100", 1'b1, 3'b100, 32'h10, 32'h12345678, 32'h0, 2'b11);
        run_check("illegal beats align", 1'b0, 3'b111, 32'h00010003, 32'h0, 32'h0, 2'b11);
        run_check("LW 0x10 after errs", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00);

        // Backpressure with a second request pending the whole time.
        @(negedge clk);
        e0 = en_count;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        req_funct3 = 3'b100; req_addr = 32'h20;
        @(posedge clk); #1;
        check("bp rsp_valid first", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp rsp_valid held", {31'd0, rsp_valid}, 32'd1);
            check("bp rsp_rdata held", rsp_rdata, 32'hDEADBEEF);
            check("bp req_ready low", {31'd0, req_ready}, 32'd0);
        end
        check("bp single access", en_count - e0, 32'd1);
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp released rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp released req_ready", {31'd0, req_ready}, 32'd1);
        check("bp not yet accepted", {31'd0, mem_en}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp second accepted", {31'd0, mem_en}, 32'd1);
        check("bp second addr", mem_addr, 32'h20);
        @(posedge clk); #1;
        check("bp second rdata", rsp_rdata, 32'h00000080);
        @(posedge clk); #1;

        // Reset during ACCESS of a store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst-mid in access", {31'd0, mem_en}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rst-mid");
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst-mid no rsp", {31'd0, rsp_valid}, 32'd0);
            check("rst-mid req_ready", {31'd0, req_ready}, 32'd1);
        end

        // Back-to-back loads with req_valid held high.
        f3s   = '{3'b010, 3'b100, 3'b001, 3'b000};
        addrs = '{32'h10, 32'h20, 32'h22, 32'h13};
        exps  = '{32'hDEADBEEF, 32'h00000080, 32'hFFFF8001, 32'hFFFFFFDE};
        rq.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3s[i]; req_addr = addrs[i];
            rdy = req_ready;
            k = 0;
            while (!rdy && k < 10) begin
                @(negedge clk);
                rdy = req_ready;
                k++;
            end
            @(posedge clk); #1;
            acc[i] = cyc;
        end
        @(negedge clk); req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++) check("b2b accept spacing", acc[i] - acc[i-1], 32'd3);
        check("b2b rsp count", rq.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rq.size()) check("b2b rdata", rq[i], exps[i]);
            else check("b2b missing rsp", 32'd0, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
